// File: rtl/roteamento_pkg.sv
// Shared types and constants for the roteamento_arb channel router.
package roteamento_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_t;

    typedef enum logic {EMPTY, FULL} state_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/roteamento_arb_rr_arbiter.sv
// Combinational cyclic-priority search: first requester after ptr, wrapping, ptr itself last.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
)(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0] N_CH_X = (SEL_W+1)'(N_CH);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = N_CH; k >= 1; k--) begin
            sum  = {1'b0, ptr} + (SEL_W+1)'(k);
            cand = SEL_W'((sum >= N_CH_X) ? (sum - N_CH_X) : sum);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/roteamento_arb.sv
// N-channel handshaked router with fixed-select or round-robin arbitration and a one-word output register.
// Optional transfer counter port xfer_count is enabled by defining ROTEAMENTO_STATS_EN.
module roteamento_arb
    import roteamento_pkg::*;
#(
    parameter int  N_BITS = 4,
    parameter int  N_CH   = 4,
    localparam int SEL_W  = $clog2(N_CH)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] in_data [N_CH],
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [N_BITS-1:0] out_data,
    output logic [SEL_W-1:0]  out_src,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ROTEAMENTO_STATS_EN
    ,
    output logic [STATS_W-1:0] xfer_count
`endif
);

    localparam logic [SEL_W:0] N_CH_X = (SEL_W+1)'(N_CH);

    state_t            state, state_next;
    logic [SEL_W-1:0]  rr_ptr, rr_ptr_next;
    logic [N_BITS-1:0] data_p0, data_next;
    logic [SEL_W-1:0]  src_p0, src_next;

    logic              rr_gnt_valid;
    logic [SEL_W-1:0]  rr_gnt_idx;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic              can_load;
    logic              load;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // Out-of-range sel simply yields no grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode_t'(mode) == MODE_RR) begin
            grant_valid = rr_gnt_valid;
            grant_idx   = rr_gnt_idx;
        end else if ({1'b0, sel} < N_CH_X) begin
            grant_valid = in_valid[sel];
            grant_idx   = sel;
        end
    end

    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) | (out_ready & out_valid);
    // Reset masks acceptance so no producer sees a handshake that the register will drop.
    assign load      = can_load & grant_valid & ~reset;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        data_next   = data_p0;
        src_next    = src_p0;
        rr_ptr_next = rr_ptr;
        if (load) begin
            state_next = FULL;
            data_next  = in_data[grant_idx];
            src_next   = grant_idx;
            if (mode_t'(mode) == MODE_RR) begin
                rr_ptr_next = grant_idx;
            end
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Stage p0: output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= EMPTY;
            rr_ptr  <= SEL_W'(N_CH - 1);
            data_p0 <= '0;
            src_p0  <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            data_p0 <= data_next;
            src_p0  <= src_next;
        end
    end

    assign out_data = data_p0;
    assign out_src  = src_p0;

`ifdef ROTEAMENTO_STATS_EN
    logic [STATS_W-1:0] xfer_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    assign xfer_count = xfer_cnt;
`endif

endmodule

// File: tb/tb_roteamento_arb.sv
// Randomized scoreboard bench for roteamento_arb against a queue-based reference model.
module tb_roteamento_arb;

    localparam int NCH = 4;

    typedef struct {
        int d;
        int s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data [NCH];
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic       mode = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_valid;
    logic       out_ready = 1'b0;

    logic [3:0] in_data3 [3];
    logic [2:0] in_valid3 = '0;
    logic [2:0] in_ready3;
    logic [1:0] sel3 = '0;
    logic [3:0] out_data3;
    logic [1:0] out_src3;
    logic       out_valid3;
`ifdef ROTEAMENTO_STATS_EN
    logic [15:0] xfer_count;
    logic [15:0] xfer_count3;
    int          m_cnt = 0;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   m_full = 0;
    int   m_ptr  = NCH - 1;
    bit   flush_pend = 0;
    bit   chk_en = 0;
    logic [3:0] exp_ready = '0;
    bit   exp_valid = 0;

    always #5 clk = ~clk;

    roteamento_arb #(.N_BITS(4), .N_CH(NCH)) dut (
        .clock     (clk),
        .reset     (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROTEAMENTO_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    roteamento_arb #(.N_BITS(4), .N_CH(3)) dut3 (
        .clock     (clk),
        .reset     (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (1'b0),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (1'b1)
`ifdef ROTEAMENTO_STATS_EN
        ,
        .xfer_count(xfer_count3)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level grant: fixed index if in range and requesting, else cyclic scan after m_ptr.
    function automatic int model_grant(input logic [3:0] iv, input logic md, input logic [1:0] sl);
        int i;
        if (!md) begin
            if (int'(sl) < NCH && iv[sl]) return int'(sl);
            return -1;
        end
        for (int k = 1; k <= NCH; k++) begin
            i = (m_ptr + k) % NCH;
            if (iv[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [3:0] iv, input logic md,
                        input logic [1:0] sl, input logic ordy, input logic [15:0] dv);
        int  g;
        bit  can;
        exp_t e;
        @(posedge clk);
        #1;
        if (flush_pend) begin
            sb.delete();
            flush_pend = 0;
        end
        rst       = r;
        in_valid  = iv;
        mode      = md;
        sel       = sl;
        out_ready = ordy;
        for (int i = 0; i < NCH; i++) in_data[i] = dv[4*i +: 4];
        #1;
        exp_valid = m_full;
        g   = model_grant(iv, md, sl);
        can = !m_full || ordy;
        exp_ready = (!r && can && g >= 0) ? 4'(1 << g) : 4'b0000;
        if (r) begin
            m_full     = 0;
            m_ptr      = NCH - 1;
            flush_pend = 1;
        end else if (exp_ready != 0) begin
            e.d = int'(dv[4*g +: 4]);
            e.s = g;
            sb.push_back(e);
            m_full = 1;
            if (md) m_ptr = g;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("out_valid", int'(out_valid), int'(exp_valid));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_empty: got out_data %0d expected no word at %0t", out_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), e.d);
                    chk("out_src", int'(out_src), e.s);
                end
            end
`ifdef ROTEAMENTO_STATS_EN
            chk("xfer_count", int'(xfer_count), m_cnt);
            if (rst) m_cnt = 0;
            else if (exp_valid && out_ready && m_cnt != 16'hFFFF) m_cnt++;
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NCH; i++) in_data[i] = '0;
        for (int i = 0; i < 3; i++) in_data3[i] = '0;

        // Reset held with all channels requesting
        step(1, 4'hF, 0, 0, 1, 16'hFFFF);
        step(1, 4'hF, 1, 0, 1, 16'hFFFF);
        @(negedge clk);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Fixed select of channel 2
        step(0, 4'b0100, 0, 2, 1, 16'h0A00);
        step(0, 4'b0000, 0, 2, 1, 16'h0000);
        step(0, 4'b0000, 0, 2, 1, 16'h0000);

        // Round-robin fairness with all requesting
        for (int n = 0; n < 6; n++) step(0, 4'hF, 1, 0, 1, 16'h8765);
        step(0, 4'h0, 1, 0, 1, 16'h0000);
        step(0, 4'h0, 1, 0, 1, 16'h0000);

        // Backpressure: hold 3 while stalled, then reload without bubble
        step(0, 4'hF, 0, 1, 0, 16'h0030);
        for (int n = 0; n < 3; n++) step(0, 4'hF, 0, 1, 0, 16'($urandom));
        step(0, 4'hF, 0, 2, 1, 16'h0C00);
        step(0, 4'h0, 0, 2, 1, 16'h0000);
        step(0, 4'h0, 0, 2, 1, 16'h0000);

        // Skip idle channels: move pointer to 0, then 1001 grants 3 then 0
        step(0, 4'b0001, 1, 0, 1, 16'h0001);
        step(0, 4'b1001, 1, 0, 1, 16'h9002);
        step(0, 4'b1001, 1, 0, 1, 16'h9002);
        step(0, 4'b0000, 1, 0, 1, 16'h0000);
        step(0, 4'b0000, 1, 0, 1, 16'h0000);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom),
                 2'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom));
        end
        step(1, 4'h0, 0, 0, 1, 16'h0000);
        step(0, 4'h0, 0, 0, 1, 16'h0000);

        // Three-channel instance: sel=3 gives no grant
        in_valid3 = 3'b111;
        sel3 = 2'd3;
        for (int n = 0; n < 3; n++) begin
            step(0, 4'h0, 0, 0, 1, 16'h0000);
            in_valid3 = 3'b111;
            @(negedge clk);
            chk("n3_sel3_in_ready", int'(in_ready3), 0);
            chk("n3_sel3_out_valid", int'(out_valid3), 0);
        end
        step(0, 4'h0, 0, 0, 1, 16'h0000);
        sel3 = 2'd2;
        in_data3[2] = 4'h9;
        in_valid3 = 3'b100;
        @(negedge clk);
        chk("n3_sel2_in_ready", int'(in_ready3), 4);
        step(0, 4'h0, 0, 0, 1, 16'h0000);
        in_valid3 = 3'b000;
        @(negedge clk);
        chk("n3_out_valid", int'(out_valid3), 1);
        chk("n3_out_data", int'(out_data3), 9);
        chk("n3_out_src", int'(out_src3), 2);

        step(0, 4'h0, 0, 0, 1, 16'h0000);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
